// File: rtl/bt_pkg.sv
// Shared definitions for the bluetooth status link (transmitter and receiver).
// Holds the frame header byte, the frame length, the top-level FSM state
// encoding and the frame checksum helper.
package bt_pkg;

  localparam logic [7:0]  FrameHdr = 8'hA5;
  localparam int unsigned FrameLen = 5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StDone
  } bt_state_e;

  // Checksum is the 8-bit wrapping sum of the four payload-preceding bytes.
  function automatic logic [7:0] frame_checksum(input logic [2:0] cur, input logic [15:0] vol);
    return FrameHdr + {5'b0, cur} + vol[15:8] + vol[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
// Ports:
//   CLK, RST  - system clock, asynchronous active-high reset
//   start     - begin sending data; accepted only while ready is high
//   data      - byte to send, LSB first
//   TXD       - registered serial output, idle high
//   ready     - high when idle and during the last two cycles of the stop bit,
//               so a caller can issue the next start with no gap after the stop bit
// BIT_CYCLES must be at least 2.
module uart_tx_byte #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TXD,
  output logic       ready
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCyc  = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] EarlyCyc = CntW'(BIT_CYCLES - 2);
  localparam logic [3:0]      StopBit  = 4'd9;

  logic            active_q, active_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [8:0]      sh_q, sh_d;
  logic            txd_q, txd_d;

  // One cycle of lookahead lets the caller's FSM spend a cycle presenting start.
  assign ready = !active_q || (bit_q == StopBit && cyc_q >= EarlyCyc);
  assign TXD   = txd_q;

  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    sh_d     = sh_q;
    txd_d    = txd_q;
    if (start && ready) begin
      active_d = 1'b1;
      bit_d    = '0;
      cyc_d    = '0;
      sh_d     = {1'b1, data};  // data bits followed by the stop bit
      txd_d    = 1'b0;          // start bit
    end else if (active_q) begin
      if (cyc_q == LastCyc) begin
        cyc_d = '0;
        if (bit_q == StopBit) begin
          active_d = 1'b0;
          txd_d    = 1'b1;
        end else begin
          txd_d = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      cyc_q    <= '0;
      sh_q     <= '0;
      txd_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      sh_q     <= sh_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: rtl/bt_status_tx.sv
// Sends a 5-byte status frame (A5, current, vol hi, vol lo, checksum) over a
// UART line whenever the song index or volume changes, or on request.
// Ports:
//   CLK, RST   - system clock, asynchronous active-high reset
//   current    - index of the playing song
//   vol        - current volume word
//   send_req   - single-cycle request to force one frame
//   TXD        - serial line, idle high
//   busy       - high while a frame is in flight
//   frame_done - one-cycle pulse after the last stop bit
module bt_status_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned BIT_CYCLES = CLK_FREQ / BAUD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  current,
  input  logic [15:0] vol,
  input  logic        send_req,
  output logic        TXD,
  output logic        busy,
  output logic        frame_done
);

  import bt_pkg::*;

  localparam logic [2:0] LastIdx = 3'(FrameLen - 1);

  bt_state_e   state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  sh_cur_q;
  logic [15:0] sh_vol_q;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        done_q;
  logic        ready_q;
  logic        trigger, latch;
  logic        tx_start, tx_ready;
  logic [7:0]  tx_data;

  assign trigger = send_req | pending_q | (current != sh_cur_q) | (vol != sh_vol_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    latch    = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          latch   = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        tx_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        // Rising ready marks the second-to-last stop-bit cycle: start the next
        // byte so its start bit follows the stop bit directly. For the last
        // byte, wait until the final stop-bit cycle instead.
        if (idx_q != LastIdx) begin
          if (tx_ready && !ready_q) begin
            idx_d   = idx_q + 3'd1;
            state_d = StSend;
          end
        end else if (tx_ready && ready_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (latch) begin
      pending_d = 1'b0;
    end else if (send_req && state_q != StIdle) begin
      pending_d = 1'b1;
    end
    busy_d = busy_q;
    if (state_q == StLoad) begin
      busy_d = 1'b1;
    end else if (state_q == StDone) begin
      busy_d = 1'b0;
    end
  end

  // Frame bytes come only from the shadow copy, which is frozen outside IDLE.
  always_comb begin
    case (idx_q)
      3'd0:    tx_data = FrameHdr;
      3'd1:    tx_data = {5'b0, sh_cur_q};
      3'd2:    tx_data = sh_vol_q[15:8];
      3'd3:    tx_data = sh_vol_q[7:0];
      default: tx_data = frame_checksum(sh_cur_q, sh_vol_q);
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      sh_cur_q  <= '0;
      sh_vol_q  <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= (state_d == StDone);
      ready_q   <= tx_ready;
      if (latch) begin
        sh_cur_q <= current;
        sh_vol_q <= vol;
      end
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;

  uart_tx_byte #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart_tx_byte (
    .CLK  (CLK),
    .RST  (RST),
    .start(tx_start),
    .data (tx_data),
    .TXD  (TXD),
    .ready(tx_ready)
  );

endmodule

// File: tb/tb_bt_status_tx.sv
module tb_bt_status_tx;

  localparam int Bc = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  current = '0;
  logic [15:0] vol = '0;
  logic        send_req = 1'b0;
  logic        TXD, busy, frame_done;

  int vectors = 0;
  int miscompares = 0;

  bt_status_tx #(
    .BIT_CYCLES(Bc)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .current   (current),
    .vol       (vol),
    .send_req  (send_req),
    .TXD       (TXD),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  // Line monitor: UART receiver sampling mid-bit, transition spacing and
  // frame_done pulse accounting.
  int         cyc = 0;
  int         rx_phase = -1;
  int         rx_bit;
  int         ferr = 0;
  int         bad_space = 0;
  int         last_tr = -1;
  int         done_cnt = 0;
  int         long_done = 0;
  logic       prev_txd = 1'b1;
  logic       prev_done = 1'b0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      rx_phase = -1;
      last_tr  = -1;
    end else begin
      if (rx_phase < 0) begin
        if (TXD === 1'b0) rx_phase = 0;
      end else begin
        rx_phase++;
      end
      if (rx_phase >= 0 && (rx_phase % Bc) == Bc / 2) begin
        rx_bit = rx_phase / Bc;
        if (rx_bit == 0) begin
          if (TXD !== 1'b0) ferr++;
        end else if (rx_bit <= 8) begin
          rx_sh[rx_bit-1] = TXD;
        end else begin
          if (TXD !== 1'b1) ferr++;
          rx_q.push_back(rx_sh);
          rx_phase = -1;
        end
      end
      if (busy === 1'b1) begin
        if (TXD !== prev_txd) begin
          if (last_tr >= 0 && ((cyc - last_tr) % Bc) != 0) bad_space++;
          last_tr = cyc;
        end
      end else begin
        last_tr = -1;
      end
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (prev_done === 1'b1) long_done++;
    end
    prev_done = frame_done;
    prev_txd  = TXD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, song index, volume bytes, 8-bit sum of the four.
  function automatic logic [7:0] model_byte(input int i, input int c, input int v);
    int b[5];
    b[0] = 165;
    b[1] = c;
    b[2] = v / 256;
    b[3] = v % 256;
    b[4] = (b[0] + b[1] + b[2] + b[3]) % 256;
    return 8'(b[i]);
  endfunction

  task automatic expect_frame(input string tag, input int c, input int v);
    logic [31:0] o;
    check($sformatf("%s len", tag), rx_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      o = 'x;
      if (i < rx_q.size()) o = {24'd0, rx_q[i]};
      check($sformatf("%s byte%0d", tag, i), o, {24'd0, model_byte(i, c, v)});
    end
    rx_q.delete();
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 600) check($sformatf("%s frame_done timeout", tag), frame_done, 1);
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    @(negedge CLK);
    send_req = 1'b0;
  endtask

  initial begin
    int          n;
    int          sc, sv;
    int          mode;
    int          base;
    logic [2:0]  rc;
    logic [15:0] rv;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset TXD", TXD, 1);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check("no frame for 0/0 busy", busy, 0);
    check("no frame for 0/0 rx", rx_q.size(), 0);

    // Single frame on input change, with start timing
    current = 3'd3;
    vol     = 16'h2020;
    @(negedge CLK);
    check("k busy", busy, 0);
    check("k TXD", TXD, 1);
    @(negedge CLK);
    check("k+1 busy", busy, 1);
    check("k+1 TXD", TXD, 1);
    @(negedge CLK);
    check("k+2 TXD start", TXD, 0);
    wait_done("single", n);
    check("single bit cycles", n, 200);
    expect_frame("single", 3, 16'h2020);
    check("single checksum", {24'd0, model_byte(4, 3, 16'h2020)}, 32'hE8);
    @(negedge CLK);
    check("single busy falls", busy, 0);
    check("single pulse width", frame_done, 0);
    check("single done count", done_cnt, 1);
    sc = 3;
    sv = 16'h2020;

    // Forced resend with unchanged inputs
    repeat (5) @(negedge CLK);
    pulse_req();
    check("resend k TXD", TXD, 1);
    @(negedge CLK);
    check("resend k+1 TXD", TXD, 1);
    @(negedge CLK);
    check("resend k+2 TXD", TXD, 0);
    wait_done("resend", n);
    expect_frame("resend", sc, sv);

    // Volume changes during byte 2: second frame follows right after DONE
    repeat (5) @(negedge CLK);
    pulse_req();
    repeat (90) @(negedge CLK);
    vol = 16'h3030;
    wait_done("mid f1", n);
    expect_frame("mid f1", 3, 16'h2020);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (TXD !== 1'b0 && n < 50);
    check("mid restart gap", n, 4);
    wait_done("mid f2", n);
    expect_frame("mid f2", 3, 16'h3030);
    sv = 16'h3030;
    repeat (60) @(negedge CLK);
    check("mid quiet", busy, 0);

    // send_req in the frame_done cycle -> exactly one extra frame
    base = done_cnt;
    pulse_req();
    wait_done("coll f1", n);
    send_req = 1'b1;
    expect_frame("coll f1", sc, sv);
    @(negedge CLK);
    send_req = 1'b0;
    wait_done("coll f2", n);
    expect_frame("coll f2", sc, sv);
    repeat (300) @(negedge CLK);
    check("coll frame count", done_cnt - base, 2);
    check("coll quiet", busy, 0);

    // Two requests during one frame -> exactly one extra frame
    base = done_cnt;
    pulse_req();
    repeat (30) @(negedge CLK);
    pulse_req();
    repeat (30) @(negedge CLK);
    pulse_req();
    repeat (500) @(negedge CLK);
    check("double req frame count", done_cnt - base, 2);
    rx_q.delete();

    // Reset in byte 1 aborts the frame
    pulse_req();
    repeat (50) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort TXD", TXD, 1);
    check("abort busy", busy, 0);
    @(negedge CLK);
    current = 3'd0;
    vol     = 16'h0000;
    @(negedge CLK);
    RST = 1'b0;
    rx_q.delete();
    repeat (30) @(negedge CLK);
    check("post-reset quiet busy", busy, 0);
    check("post-reset quiet rx", rx_q.size(), 0);
    current = 3'd1;
    wait_done("post-reset", n);
    expect_frame("post-reset", 1, 0);
    check("post-reset checksum", {24'd0, model_byte(4, 1, 0)}, 32'hA6);
    sc = 1;
    sv = 0;
    repeat (3) @(negedge CLK);

    // Randomized rounds against the shadow model
    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 2));
      repeat (3) @(negedge CLK);
      if (mode == 0) begin
        rc = 3'($urandom);
        rv = 16'($urandom);
        if (int'(rc) == sc && int'(rv) == sv) rv = rv + 16'd1;
        current = rc;
        vol     = rv;
        sc      = int'(rc);
        sv      = int'(rv);
        wait_done("rand new", n);
        expect_frame("rand new", sc, sv);
      end else if (mode == 1) begin
        pulse_req();
        wait_done("rand req", n);
        expect_frame("rand req", sc, sv);
      end else begin
        repeat (40) @(negedge CLK);
        check("rand quiet busy", busy, 0);
        check("rand quiet rx", rx_q.size(), 0);
      end
      repeat (3) @(negedge CLK);
    end

    check("framing errors", ferr, 0);
    check("bit spacing", bad_space, 0);
    check("frame_done width", long_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bt_status_tx.md
BT_STATUS_TX -- requirements
Module: bt_status_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter BIT_CYCLES, default CLK_FREQ/BAUD (integer division, 10416), clock cycles per serial bit; the bench overrides it.
REQ-004 Port CLK, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port RST, input, 1, asynchronous active-high reset.
REQ-006 Port current, input, 3, index of the currently playing song.
REQ-007 Port vol, input, 16, current mp3 volume word.
REQ-008 Port send_req, input, 1, single-cycle request to force one status frame.
REQ-009 Port TXD, output, 1, UART serial line to the bluetooth module; idle high.
REQ-010 Port busy, output, 1, high while a frame is being transmitted.
REQ-011 Port frame_done, output, 1, one-cycle pulse after the last stop bit of a frame.

Function
REQ-012 Each byte SHALL be sent as 8N1:
- start bit 0
- 8 data bits, LSB first
- stop bit 1
- every bit held exactly BIT_CYCLES cycles.
REQ-013 A frame SHALL be 5 bytes, sent back-to-back with no idle gap between stop bit and next start bit:
- 0xA5
- {5'b0, current}
- vol[15:8]
- vol[7:0]
- checksum = (sum of the first four bytes) mod 256.
REQ-014 A frame SHALL be triggered in IDLE by either:
- send_req high, or
- (current, vol) differing from the shadow registers holding the last-sent values.
REQ-015 At frame start, current and vol SHALL be latched into the shadow registers, and the frame SHALL use only the latched values.
REQ-016 Frame start timing:
- trigger sampled at edge k;
- TXD start bit SHALL begin at edge k+2;
- busy SHALL rise at edge k+1.
REQ-017 While busy, send_req SHALL set a pending flag; on return to IDLE the pending flag, or any shadow mismatch, SHALL start the next frame with no further request.
REQ-018 send_req in the same cycle as frame_done SHALL be captured as pending, not lost.
REQ-019 Top-level FSM states: IDLE -> LOAD (latch, build frame) -> SEND (start byte i) -> WAIT (byte busy) -> SEND while i<4, else DONE -> IDLE.
REQ-020 DONE SHALL last one cycle; frame_done SHALL be asserted in DONE and busy SHALL fall at the same edge that leaves DONE.
REQ-021 TXD SHALL be registered (glitch-free) and high in every cycle outside start/data bits.

Reset
REQ-022 On RST, all of the following SHALL reset asynchronously:
- TXD=1, busy=0, frame_done=0
- FSM=IDLE, byte index=0
- shadow current=0, shadow vol=0
- pending=0
- bit and cycle counters=0.
REQ-023 RST asserted mid-frame SHALL abort the frame, and TXD SHALL be 1 from the reset edge.
REQ-024 After release, inputs equal to the reset shadow values (0, 0) SHALL NOT trigger a frame.

Structure
REQ-025 Frame header 0xA5, frame length 5, and the FSM state encoding SHALL live in a shared package (bt_pkg) used together with the receiver.
REQ-026 The byte serializer SHALL be a sub-module uart_tx_byte:
- ports: CLK, RST, start, data[7:0], BIT_CYCLES parameter, TXD, ready;
- start is accepted only when ready is high.
REQ-027 The top-level SHALL instantiate bt_status_tx beside BlueTooth, fed from the same current and vol nets.

Verification (BIT_CYCLES=4)
REQ-028 Single frame: reset, then current=3, vol=16'h2020 -> one frame with bytes A5 03 20 20 E8 (checksum 0xE8), 200 TXD cycles of bits, then one frame_done pulse.
REQ-029 Forced resend: in IDLE with the shadow equal to the inputs, pulse send_req -> TXD low exactly 2 cycles later; frame repeats the latched values.
REQ-030 Mid-frame change: change vol to 16'h3030 during byte 2 -> current frame still carries 0x20 bytes; a second frame with 30 30 follows back-to-back after DONE.
REQ-031 Request collisions: send_req coinciding with frame_done -> exactly one extra frame; two send_req pulses during one frame -> exactly one extra frame.
REQ-032 Reset mid-frame: assert RST during byte 1 -> TXD=1 and busy=0 immediately; after release with inputs 0/0 there is no frame, and with current=1 there is a frame A5 01 00 00 A6.
REQ-033 Bit timing: measure every TXD transition during a frame -> spacing is a multiple of 4 cycles; a receiver model decodes all 5 bytes with no framing error.
